sreg_wb_arbiter: RTL and testbench

Write-back arbiter and pending-write scoreboard for the scalar register file's single write port. It shares that port among NUM_REQ execution units (ALU, load unit, vector-to-scalar move) using round-robin valid/ready arbitration, and registers the winner into a one-deep output stage that drives the register file's write inputs. It also tracks in-flight destinations so the issue stage can detect RAW/WAW hazards.

---
 rtl/sreg_wb_arbiter.sv | 132 +++++++++++++
 tb/tb_sreg_wb_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sreg_wb_arbiter.sv
// Round-robin write-back arbiter for the scalar register file write port, plus pending-write scoreboard.
// Optional conflict statistics counter is built only when SREG_WB_STATS_EN is defined.
module sreg_wb_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REQ    = 3
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*5-1:0]           req_rd_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_rd_data_i,
  output logic [4:0]                     rd_addr_o,
  output logic [DATA_WIDTH-1:0]          rd_data_o,
  output logic                           reg_write_en_o,
  input  logic                           issue_valid_i,
  input  logic [4:0]                     issue_rd_addr_i,
  output logic [31:0]                    busy_o,
  output logic [31:0]                    conflict_cnt_o
);

  localparam int unsigned AW    = 5;
  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [AW-1:0]         addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic                  wen_q, wen_d;
  logic [AW-1:0]         addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           busy_q, busy_d;

  logic [PTR_W:0]        scan;
  logic [PTR_W-1:0]      gnt_idx;
  logic                  gnt_vld;
  logic                  hs;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      addr_arr[i] = req_rd_addr_i[AW*i +: AW];
      data_arr[i] = req_rd_data_i[DATA_WIDTH*i +: DATA_WIDTH];
    end
  end

  // First valid requester found scanning upward from ptr, wrapping modulo NUM_REQ.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, ptr_q} + (PTR_W+1)'(k);
      if (scan >= (PTR_W+1)'(NUM_REQ)) scan = scan - (PTR_W+1)'(NUM_REQ);
      if (!gnt_vld && req_valid_i[scan[PTR_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = scan[PTR_W-1:0];
      end
    end
  end

  assign hs = gnt_vld & ~rst;

  always_comb begin
    req_ready_o = '0;
    if (hs) req_ready_o[gnt_idx] = 1'b1;
  end

  always_comb begin
    ptr_d  = ptr_q;
    wen_d  = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    if (hs) begin
      ptr_d  = (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + PTR_W'(1);
      addr_d = addr_arr[gnt_idx];
      data_d = data_arr[gnt_idx];
      wen_d  = (addr_arr[gnt_idx] != '0);
    end
  end

  // Set after clear so a newer writer issued on the retiring edge stays pending.
  always_comb begin
    busy_d = busy_q;
    if (wen_q) busy_d[addr_q] = 1'b0;
    if (issue_valid_i && (issue_rd_addr_i != '0)) busy_d[issue_rd_addr_i] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q  <= '0;
      wen_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      busy_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wen_q  <= wen_d;
      addr_q <= addr_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end

  assign reg_write_en_o = wen_q;
  assign rd_addr_o      = addr_q;
  assign rd_data_o      = data_q;
  assign busy_o         = busy_q;

`ifdef SREG_WB_STATS_EN
  logic [31:0] cnt_q, cnt_d;
  logic        multi_c;

  // Two or more valid bits: clearing the lowest set bit leaves something behind.
  assign multi_c = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (multi_c && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign conflict_cnt_o = cnt_q;
`else
  assign conflict_cnt_o = '0;
`endif

endmodule

// File: tb/tb_sreg_wb_arbiter.sv
// Scoreboard bench for sreg_wb_arbiter: a reference model pushes expected write-port
// results per cycle; they are popped and compared after the clock edge.
module tb_sreg_wb_arbiter;

  localparam int unsigned DW = 32;
  localparam int unsigned NR = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_valid_i = '0;
  logic [NR-1:0]    req_ready_o;
  logic [NR*5-1:0]  req_rd_addr_i = '0;
  logic [NR*DW-1:0] req_rd_data_i = '0;
  logic [4:0]       rd_addr_o;
  logic [DW-1:0]    rd_data_o;
  logic             reg_write_en_o;
  logic             issue_valid_i = 1'b0;
  logic [4:0]       issue_rd_addr_i = '0;
  logic [31:0]      busy_o;
  logic [31:0]      conflict_cnt_o;

  sreg_wb_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rd_addr_i(req_rd_addr_i), .req_rd_data_i(req_rd_data_i),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .reg_write_en_o(reg_write_en_o),
    .issue_valid_i(issue_valid_i), .issue_rd_addr_i(issue_rd_addr_i),
    .busy_o(busy_o), .conflict_cnt_o(conflict_cnt_o)
  );

  always #5 clk = ~clk;

  // Requesters must hold valid/addr/data until granted.
  for (genvar i = 0; i < NR; i++) begin : g_hold
    assert property (@(posedge clk) disable iff (rst)
      (req_valid_i[i] && !req_ready_o[i]) |=>
        (req_valid_i[i] && $stable(req_rd_addr_i[5*i +: 5]) && $stable(req_rd_data_i[DW*i +: DW])));
  end

  typedef struct packed {
    logic          wen;
    logic [4:0]    addr;
    logic [DW-1:0] data;
  } wb_t;

  wb_t         exp_q[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          m_ptr;
  logic        m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_busy;
  logic [31:0] m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_wen = 1'b0; m_addr = '0; m_data = '0; m_busy = '0; m_cnt = '0;
    exp_q.delete();
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_rd_addr_i[5*i +: 5]   = a;
    req_rd_data_i[DW*i +: DW] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid_i = '0;
    issue_valid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
  endtask

  // One clock: drive, check grant, predict, step, compare.
  task automatic cycle(input logic [NR-1:0] v, input logic iv, input logic [4:0] ia);
    int          g;
    int          idx;
    logic [NR-1:0] exp_rdy;
    logic [31:0] nb;
    wb_t         e;
    req_valid_i = v; issue_valid_i = iv; issue_rd_addr_i = ia;
    #1;
    g = -1;
    for (int k = 0; k < NR; k++) begin
      idx = (m_ptr + k) % NR;
      if (g < 0 && v[idx]) g = idx;
    end
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    check_eq("ready", 32'(req_ready_o), 32'(exp_rdy));
    nb = m_busy;
    if (m_wen) nb[m_addr] = 1'b0;
    if (iv && ia != 5'd0) nb[ia] = 1'b1;
    if (g >= 0) begin
      m_addr = req_rd_addr_i[5*g +: 5];
      m_data = req_rd_data_i[DW*g +: DW];
      m_wen  = (m_addr != 5'd0);
      m_ptr  = (g + 1) % NR;
    end else begin
      m_wen = 1'b0;
    end
    m_busy = nb;
`ifdef SREG_WB_STATS_EN
    if (($countones(v) >= 2) && (m_cnt != 32'hFFFF_FFFF)) m_cnt = m_cnt + 32'd1;
`endif
    exp_q.push_back('{wen: m_wen, addr: m_addr, data: m_data});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("wen",  32'(reg_write_en_o), 32'(e.wen));
    check_eq("addr", 32'(rd_addr_o), 32'(e.addr));
    check_eq("data", rd_data_o, e.data);
    check_eq("busy", busy_o, m_busy);
    check_eq("cnt",  conflict_cnt_o, m_cnt);
  endtask

  initial begin
    model_reset();
    // Reset state and ready gating while rst is high
    req_valid_i = 3'b111;
    #1;
    check_eq("rst_ready", 32'(req_ready_o), 32'd0);
    do_reset();
    check_eq("rst_wen",  32'(reg_write_en_o), 32'd0);
    check_eq("rst_addr", 32'(rd_addr_o), 32'd0);
    check_eq("rst_data", rd_data_o, 32'd0);
    check_eq("rst_busy", busy_o, 32'd0);
    check_eq("rst_cnt",  conflict_cnt_o, 32'd0);

    // Single request
    set_req(0, 5'd5, 32'hDEAD_BEEF);
    cycle(3'b001, 1'b0, 5'd0);
    check_eq("single_wen",  32'(reg_write_en_o), 32'd1);
    check_eq("single_data", rd_data_o, 32'hDEAD_BEEF);
    cycle(3'b000, 1'b0, 5'd0);
    check_eq("single_idle", 32'(reg_write_en_o), 32'd0);

    // Round-robin under full load, then drain the waiting requesters
    do_reset();
    set_req(0, 5'd1, 32'hA000_0000);
    set_req(1, 5'd2, 32'hA111_1111);
    set_req(2, 5'd3, 32'hA222_2222);
    repeat (6) cycle(3'b111, 1'b0, 5'd0);
`ifdef SREG_WB_STATS_EN
    check_eq("rr_cnt", conflict_cnt_o, 32'd6);
`else
    check_eq("rr_cnt", conflict_cnt_o, 32'd0);
`endif
    cycle(3'b011, 1'b0, 5'd0);
    cycle(3'b010, 1'b0, 5'd0);
    cycle(3'b000, 1'b0, 5'd0);

    // x0 discard: consumes grant, no write, ptr moves to requester 2
    set_req(1, 5'd0, 32'h0000_1234);
    set_req(2, 5'd9, 32'h9999_0000);
    cycle(3'b010, 1'b0, 5'd0);
    check_eq("x0_wen", 32'(reg_write_en_o), 32'd0);
    cycle(3'b111, 1'b0, 5'd0);
    check_eq("x0_next_addr", 32'(rd_addr_o), 32'd9);
    cycle(3'b011, 1'b0, 5'd0);
    cycle(3'b010, 1'b0, 5'd0);
    cycle(3'b000, 1'b0, 5'd0);

    // Scoreboard set/clear and set-wins on the clearing edge
    cycle(3'b000, 1'b1, 5'd7);
    check_eq("sb_set", 32'(busy_o[7]), 32'd1);
    cycle(3'b000, 1'b0, 5'd0);
    set_req(2, 5'd7, 32'h0000_0077);
    cycle(3'b100, 1'b0, 5'd0);
    cycle(3'b000, 1'b1, 5'd7);
    check_eq("sb_reissue", 32'(busy_o[7]), 32'd1);
    cycle(3'b100, 1'b0, 5'd0);
    cycle(3'b000, 1'b0, 5'd0);
    check_eq("sb_clear", 32'(busy_o[7]), 32'd0);
    cycle(3'b000, 1'b1, 5'd0);

    // Reset mid-operation with a write in flight
    cycle(3'b000, 1'b1, 5'd5);
    cycle(3'b000, 1'b1, 5'd7);
    set_req(0, 5'd3, 32'h3333_3333);
    cycle(3'b001, 1'b0, 5'd0);
    check_eq("mid_busy", busy_o, 32'h0000_00A0);
    check_eq("mid_wen",  32'(reg_write_en_o), 32'd1);
    req_valid_i = 3'b111;
    rst = 1'b1;
    #1;
    check_eq("arst_wen",   32'(reg_write_en_o), 32'd0);
    check_eq("arst_busy",  busy_o, 32'd0);
    check_eq("arst_ready", 32'(req_ready_o), 32'd0);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    cycle(3'b111, 1'b0, 5'd0);
    check_eq("arst_first", 32'(rd_addr_o), 32'd3);
    cycle(3'b110, 1'b0, 5'd0);
    cycle(3'b100, 1'b0, 5'd0);
    cycle(3'b000, 1'b0, 5'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
